// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one memory port, with ownership locking and a burst limit.
// Define MEM_ARB_RR_EN for round-robin tie-breaks; by default requester A wins ties.
module mem_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_lock,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_lock,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [1:0]            owner
);

    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    state_t          state;
    logic [BW-1:0]   burst_cnt;
    logic            last_grant_b;
    logic            a_rv;
    logic            b_rv;

    logic            grant_a;
    logic            grant_b;
    logic            from_owner;
    logic            burst_left;
    logic            tie_a;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        from_owner = 1'b0;
        burst_left = (burst_cnt < BW'(MAX_BURST));
`ifdef MEM_ARB_RR_EN
        tie_a = last_grant_b;
`else
        tie_a = 1'b1;
`endif
        // An owner that has used up its burst yields the tie to the other requester.
        if (state == OWN_A && !burst_left)
            tie_a = 1'b0;
        else if (state == OWN_B && !burst_left)
            tie_a = 1'b1;

        if (state == OWN_A && a_req && (burst_left || !b_req)) begin
            grant_a    = 1'b1;
            from_owner = 1'b1;
        end else if (state == OWN_B && b_req && (burst_left || !a_req)) begin
            grant_b    = 1'b1;
            from_owner = 1'b1;
        end else if (a_req && b_req) begin
            grant_a = tie_a;
            grant_b = !tie_a;
        end else begin
            grant_a = a_req;
            grant_b = b_req;
        end
    end

    assign a_gnt = rst_n & grant_a;
    assign b_gnt = rst_n & grant_b;

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (a_gnt) begin
            mem_we   = a_we;
            mem_addr = a_addr;
            mem_din  = a_wdata;
        end else if (b_gnt) begin
            mem_we   = b_we;
            mem_addr = b_addr;
            mem_din  = b_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            burst_cnt    <= '0;
            last_grant_b <= 1'b1;
            a_rv         <= 1'b0;
            b_rv         <= 1'b0;
        end else begin
            a_rv <= grant_a & ~a_we;
            b_rv <= grant_b & ~b_we;
            if (grant_a || grant_b) begin
                last_grant_b <= grant_b;
                if (!from_owner)
                    burst_cnt <= BW'(1);
                else if (burst_left)
                    burst_cnt <= burst_cnt + BW'(1);
            end
            if (grant_a)
                state <= a_lock ? OWN_A : IDLE;
            else if (grant_b)
                state <= b_lock ? OWN_B : IDLE;
            else
                state <= IDLE;
        end
    end

    assign owner    = state;
    assign a_rvalid = a_rv;
    assign b_rvalid = b_rv;
    assign a_rdata  = mem_dout;
    assign b_rdata  = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for routing and read latency,
// plus hand-written sequences for burst limit, saturation, tie policy and reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req, a_lock, a_we, b_req, b_lock, b_we;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, mem_we;
    logic [15:0] a_rdata, b_rdata, mem_addr, mem_din;
    logic [15:0] mem_dout = '0;
    logic [1:0]  owner;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .owner(owner)
    );

    always #5 clk = ~clk;

    // Registered memory model: read data is a fixed function of the previous address.
    always @(posedge clk) mem_dout <= mem_addr ^ 16'hA5A5;

    typedef struct {
        logic        a_req, a_we;
        logic [15:0] a_addr, a_wdata;
        logic        b_req, b_we;
        logic [15:0] b_addr, b_wdata;
        logic        e_a_gnt, e_b_gnt, e_mem_we;
        logic [15:0] e_mem_addr, e_mem_din;
        logic        e_a_rv, e_b_rv;
        logic [15:0] e_rdata;
        logic [1:0]  e_owner;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        a_req = 0; a_lock = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_lock = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,16'h0000,2'b00};
        vecs[1]  = '{1,0,16'h0010,16'h0000, 1,0,16'h0020,16'h0000, 1,0,0,16'h0010,16'h0000, 0,0,16'h0000,2'b00};
        vecs[2]  = '{0,0,16'h0000,16'h0000, 1,0,16'h0020,16'h0000, 0,1,0,16'h0020,16'h0000, 1,0,16'hA5B5,2'b00};
        vecs[3]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,1,16'hA585,2'b00};
        vecs[4]  = '{0,0,16'h0000,16'h0000, 1,1,16'h0100,16'hBEEF, 0,1,1,16'h0100,16'hBEEF, 0,0,16'h0000,2'b00};
        vecs[5]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,16'h0000,2'b00};
        vecs[6]  = '{1,0,16'h0030,16'h1234, 0,0,16'h0000,16'h0000, 1,0,0,16'h0030,16'h1234, 0,0,16'h0000,2'b00};
        vecs[7]  = '{0,0,16'h0000,16'h0000, 1,0,16'h0040,16'h0000, 0,1,0,16'h0040,16'h0000, 1,0,16'hA595,2'b00};
        vecs[8]  = '{1,0,16'h0050,16'h0000, 0,0,16'h0000,16'h0000, 1,0,0,16'h0050,16'h0000, 0,1,16'hA5E5,2'b00};
        vecs[9]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 1,0,16'hA5F5,2'b00};
        vecs[10] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000, 0,0,16'h0000,2'b00};

        // Outputs are forced low while reset is held.
        clear_inputs();
        a_req = 1; b_req = 1; b_we = 1;
        @(negedge clk); #1;
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_owner", owner, 0);
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_rvalid", b_rvalid, 0);
        do_reset();

        // Vector table: inputs driven after the falling edge, outputs checked 1 ns later.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wdata;
            b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wdata;
            a_lock = 0; b_lock = 0;
            #1;
            check($sformatf("v%0d_a_gnt", i), a_gnt, vecs[i].e_a_gnt);
            check($sformatf("v%0d_b_gnt", i), b_gnt, vecs[i].e_b_gnt);
            check($sformatf("v%0d_mem_we", i), mem_we, vecs[i].e_mem_we);
            check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_mem_addr);
            check($sformatf("v%0d_mem_din", i), mem_din, vecs[i].e_mem_din);
            check($sformatf("v%0d_a_rvalid", i), a_rvalid, vecs[i].e_a_rv);
            check($sformatf("v%0d_b_rvalid", i), b_rvalid, vecs[i].e_b_rv);
            check($sformatf("v%0d_owner", i), owner, vecs[i].e_owner);
            if (vecs[i].e_a_rv) check($sformatf("v%0d_a_rdata", i), a_rdata, vecs[i].e_rdata);
            if (vecs[i].e_b_rv) check($sformatf("v%0d_b_rdata", i), b_rdata, vecs[i].e_rdata);
        end

        // Locked A against a requesting B: eight grants to A, then B takes over.
        do_reset();
        @(negedge clk);
        a_req = 1; a_lock = 1; b_req = 1; b_lock = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("burst%0d_a_gnt", i), a_gnt, 1);
            check($sformatf("burst%0d_b_gnt", i), b_gnt, 0);
            if (i > 0) check($sformatf("burst%0d_owner", i), owner, 2'b01);
            @(negedge clk);
        end
        #1;
        check("burst_end_a_gnt", a_gnt, 0);
        check("burst_end_b_gnt", b_gnt, 1);
        check("burst_end_owner", owner, 2'b01);
        @(negedge clk); #1;
        check("burst_handover_owner", owner, 2'b10);
        check("burst_handover_b_gnt", b_gnt, 1);
        clear_inputs();

        // Locked A alone: no gap over 20 requests; saturated count lets B in at once.
        do_reset();
        @(negedge clk);
        a_req = 1; a_lock = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            check($sformatf("solo%0d_a_gnt", i), a_gnt, 1);
            @(negedge clk);
        end
        b_req = 1;
        #1;
        check("sat_b_gnt", b_gnt, 1);
        check("sat_a_gnt", a_gnt, 0);
        check("sat_owner", owner, 2'b01);
        clear_inputs();

        // Continuous unlocked tie: policy depends on the build.
        do_reset();
        @(negedge clk);
        a_req = 1; b_req = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
`ifdef MEM_ARB_RR_EN
            check($sformatf("tie%0d_a_gnt", i), a_gnt, (i % 2 == 0));
            check($sformatf("tie%0d_b_gnt", i), b_gnt, (i % 2 == 1));
`else
            check($sformatf("tie%0d_a_gnt", i), a_gnt, 1);
            check($sformatf("tie%0d_b_gnt", i), b_gnt, 0);
`endif
            @(negedge clk);
        end
        clear_inputs();

        // Reset arriving before the edge of a granted read: no rvalid ever follows.
        do_reset();
        @(negedge clk);
        a_req = 1; a_addr = 16'h0060; b_req = 1; b_we = 1;
        #1;
        check("rmid_pre_a_gnt", a_gnt, 1);
        #2;
        rst_n = 0;
        #1;
        check("rmid_a_gnt", a_gnt, 0);
        check("rmid_b_gnt", b_gnt, 0);
        check("rmid_mem_we", mem_we, 0);
        @(negedge clk);
        clear_inputs();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check($sformatf("rpost%0d_a_rvalid", i), a_rvalid, 0);
            check($sformatf("rpost%0d_owner", i), owner, 0);
        end

        // Reset while a locked read's rvalid is showing: both drop immediately.
        @(negedge clk);
        a_req = 1; a_lock = 1; a_addr = 16'h0070;
        @(negedge clk);
        clear_inputs();
        #1;
        check("rlate_a_rvalid_before", a_rvalid, 1);
        check("rlate_owner_before", owner, 2'b01);
        rst_n = 0;
        #1;
        check("rlate_a_rvalid", a_rvalid, 0);
        check("rlate_owner", owner, 2'b00);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk); #1;
        check("rlate_post_a_rvalid", a_rvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of data words.
REQ-002 Parameter ADDR_WIDTH, default 16, width of memory addresses.
REQ-003 Parameter MAX_BURST, default 8, maximum consecutive locked grants to one requester while the other requests.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-006 a_req, a_lock, a_we  in  1 each  requester A: access request, ownership lock, write enable.
REQ-007 a_addr  in  ADDR_WIDTH; a_wdata  in  DATA_WIDTH  requester A address and write data.
REQ-008 a_gnt  out  1  A access accepted this cycle; a_rvalid  out  1  A read data valid; a_rdata  out  DATA_WIDTH.
REQ-009 b_req, b_lock, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata SHALL mirror REQ-006..008 for requester B.
REQ-010 mem_addr  out  ADDR_WIDTH; mem_din  out  DATA_WIDTH; mem_we  out  1  drive one dual-port memory port.
REQ-011 mem_dout  in  DATA_WIDTH  memory read data, registered by memory, valid one cycle after address.
REQ-012 owner  out  2  FSM state: 2'b00 IDLE, 2'b01 OWN_A, 2'b10 OWN_B.

Function
REQ-013 At most one of a_gnt/b_gnt SHALL be high per cycle; gnt is combinational from state, req, burst count.
REQ-014 Requester SHALL hold req/we/addr/wdata stable until gnt; gnt high means the access is issued at that rising edge.
REQ-015 During a grant, mem_addr/mem_din/mem_we SHALL equal the granted requester's addr/wdata/we; with no grant, mem_we=0, mem_addr=0, mem_din=0.
REQ-016 Read granted in cycle N SHALL produce x_rvalid high for exactly cycle N+1 with x_rdata = mem_dout; writes SHALL never raise rvalid.
REQ-017 x_rdata SHALL pass mem_dout through and be meaningful only while x_rvalid is high.
REQ-018 Fresh arbitration: one requester -> grant it; both -> grant the one not in last_grant register; none -> no grant.
REQ-019 In OWN_X: grant X if x_req and (burst_cnt < MAX_BURST or other not requesting); otherwise fresh arbitration.
REQ-020 Next state after grant to X: OWN_X if x_lock=1, else IDLE; after no grant: IDLE.
REQ-021 burst_cnt SHALL load 1 on a grant made by fresh arbitration, increment on a grant in OWN_X, saturate at MAX_BURST.
REQ-022 last_grant SHALL update to the granted requester on every grant.
REQ-023 Ownership lost to the other requester while lock is held SHALL move state to OWN_other or IDLE per REQ-020; X re-enters by fresh arbitration.
REQ-024 Back-to-back grants to alternating requesters SHALL produce correctly routed rvalid on consecutive cycles.

Reset
REQ-025 rst_n low SHALL asynchronously set state IDLE, owner=0, burst_cnt=0, last_grant=B, both rvalid pipeline bits=0.
REQ-026 While rst_n is low, a_gnt, b_gnt and mem_we SHALL be forced 0.
REQ-027 Reset mid-read SHALL drop the pending rvalid; no rvalid SHALL appear after reset release for pre-reset reads.
REQ-028 First tie after reset SHALL grant A.

Configuration
REQ-029 Macro MEM_ARB_RR_EN defined: tie-break per REQ-018 (round-robin via last_grant).
REQ-030 MEM_ARB_RR_EN undefined: A SHALL win every fresh-arbitration tie; locking and MAX_BURST SHALL still apply.

Verification
REQ-031 Reset, a_req=1 read addr 16'h0010, b_req=1 read 16'h0020 same cycle -> a_gnt first, b_gnt next cycle, rvalid A then B with respective mem_dout.
REQ-032 a_lock=1, a_req continuously, b_req=1 -> exactly 8 consecutive a_gnt, then b_gnt; owner 01 then 10.
REQ-033 b write 16'hBEEF to 16'h0100 -> mem_we=1, mem_addr=16'h0100, mem_din=16'hBEEF for one cycle; b_rvalid stays 0.
REQ-034 a read granted, rst_n low next cycle before edge -> a_rvalid never asserts; owner=00; all gnt 0 during reset.
REQ-035 MEM_ARB_RR_EN undefined, both req continuously unlocked -> a_gnt every cycle, b_gnt never.
REQ-036 a_lock=1, b_req=0, 20 A requests -> 20 consecutive a_gnt, burst_cnt saturates at 8, no gap.
